// File: rtl/store_buffer_lsu.sv
`default_nettype none
// store_buffer_lsu: posted-store FIFO and load sequencer in front of the data cache.
// Optional store-to-load forwarding is enabled by defining STB_FWD_EN.  Rev 1.0
module store_buffer_lsu #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_req_valid,
   input  logic                    i_req_write,
   input  logic [AW-1:0]           i_req_addr,
   input  logic [1:0]              i_req_size,
   input  logic [DW-1:0]           i_req_wdata,
   output logic                    o_stall,
   output logic                    o_load_valid,
   output logic [DW-1:0]           o_load_data,
   output logic [$clog2(DEPTH):0]  o_occupancy,
   output logic                    o_dreq,
   output logic                    o_dwrite,
   output logic [AW-1:0]           o_daddr,
   output logic [1:0]              o_dsize,
   output logic [DW-1:0]           o_ddata,
   input  logic [DW-1:0]           i_rdata,
   input  logic                    i_dready_n,
   input  logic                    i_dbusy
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LD_REQ  = 2'd1,
      S_LD_WAIT = 2'd2,
      S_LD_DONE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [AW-1:0]   r_addr [DEPTH];
   logic [1:0]      r_size [DEPTH];
   logic [DW-1:0]   r_data [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [DW-1:0]   r_load_data;

   logic [PW-1:0]   w_count;
   logic [IW-1:0]   w_head;
   logic            w_empty;
   logic            w_full;
   logic            w_req_store;
   logic            w_req_load;
   logic            w_push;
   logic            w_pop;
   logic            w_issue;
   logic            w_capture;
   logic            w_fwd_take;
   logic            w_fwd_hit;
   logic [DW-1:0]   w_fwd_data;

   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign w_head      = r_rd_ptr[IW-1:0];
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                        (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
   // Reset also masks the request so the pipeline sees no stall while rst_n is low.
   assign w_req_store = rst_n & i_req_valid & i_req_write;
   assign w_req_load  = rst_n & i_req_valid & ~i_req_write;
   assign w_push      = w_req_store & ~w_full;
   assign w_pop       = (r_state == S_IDLE) & ~w_empty & ~i_dbusy;

`ifdef STB_FWD_EN
   // Youngest full-word match wins; any byte/half store to the same word blocks forwarding.
   always_comb begin : p_fwd
      logic            v_match;
      logic            v_partial;
      logic [IW-1:0]   v_idx;
      v_match    = 1'b0;
      v_partial  = 1'b0;
      v_idx      = '0;
      w_fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         v_idx = w_head + IW'(k);
         if ((PW'(k) < w_count) && (r_addr[v_idx][AW-1:2] == i_req_addr[AW-1:2])) begin
            if (r_size[v_idx] == 2'b10) begin
               v_match    = 1'b1;
               w_fwd_data = r_data[v_idx];
            end else begin
               v_partial  = 1'b1;
            end
         end
      end
      w_fwd_hit = v_match & ~v_partial & (i_req_size == 2'b10);
   end
`else
   assign w_fwd_hit  = 1'b0;
   assign w_fwd_data = '0;
`endif

   // A load whose older stores are all drained issues straight from IDLE,
   // so an empty buffer gives request-to-load_valid latency of two cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_capture   = 1'b0;
      w_fwd_take  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req_load) begin
               if (w_fwd_hit) begin
                  w_fwd_take  = 1'b1;
                  w_state_nxt = S_LD_DONE;
               end else if (w_empty) begin
                  w_issue     = 1'b1;
                  w_state_nxt = i_dbusy ? S_LD_REQ : S_LD_WAIT;
               end
            end
         end
         S_LD_REQ: begin
            w_issue = 1'b1;
            if (!i_dbusy) begin
               w_state_nxt = S_LD_WAIT;
            end
         end
         S_LD_WAIT: begin
            w_issue = 1'b1;
            if (!i_dready_n) begin
               w_capture   = 1'b1;
               w_state_nxt = S_LD_DONE;
            end
         end
         S_LD_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Drain and load issue are mutually exclusive: a load issues only with an empty buffer.
   always_comb begin
      o_dreq   = 1'b0;
      o_dwrite = 1'b0;
      o_daddr  = '0;
      o_dsize  = '0;
      o_ddata  = '0;
      if (w_pop) begin
         o_dreq   = 1'b1;
         o_dwrite = 1'b1;
         o_daddr  = r_addr[w_head];
         o_dsize  = r_size[w_head];
         o_ddata  = r_data[w_head];
      end else if (w_issue) begin
         o_dreq   = 1'b1;
         o_daddr  = i_req_addr;
         o_dsize  = i_req_size;
      end
   end

   assign o_stall      = (w_req_store & w_full) | (w_req_load & (r_state != S_LD_DONE));
   assign o_load_valid = (r_state == S_LD_DONE);
   assign o_load_data  = r_load_data;
   assign o_occupancy  = w_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_load_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_capture) begin
            r_load_data <= i_rdata;
         end else if (w_fwd_take) begin
            r_load_data <= w_fwd_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr[IW-1:0]] <= i_req_addr;
         r_size[r_wr_ptr[IW-1:0]] <= i_req_size;
         r_data[r_wr_ptr[IW-1:0]] <= i_req_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_lsu.sv
`default_nettype none
// tb_store_buffer_lsu: randomized scoreboard bench; expected values come from a flat memory model.
module tb_store_buffer_lsu;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        stall, load_valid, dreq, dwrite;
   logic [31:0] load_data, daddr, ddata, rdata;
   logic [2:0]  occupancy;
   logic [1:0]  dsize;
   logic        dready_n, dbusy;

   always #5 clk = ~clk;

   store_buffer_lsu #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(req_valid), .i_req_write(req_write), .i_req_addr(req_addr),
      .i_req_size(req_size), .i_req_wdata(req_wdata),
      .o_stall(stall), .o_load_valid(load_valid), .o_load_data(load_data),
      .o_occupancy(occupancy), .o_dreq(dreq), .o_dwrite(dwrite), .o_daddr(daddr),
      .o_dsize(dsize), .o_ddata(ddata), .i_rdata(rdata), .i_dready_n(dready_n),
      .i_dbusy(dbusy)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] data;
   } st_t;

   st_t         exp_st[$];
   logic [31:0] exp_ld[$];
   logic [31:0] ref_mem   [int unsigned];
   logic [31:0] cache_mem [int unsigned];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          last_drain_cyc = 0;
   int          last_lv_cyc = 0;
   int          drain_cnt = 0;
   int          busy_mode = 2;   // 0 random, 1 always busy, 2 never busy
   int          ready_mode = 2;  // 0 random, 1 never ready, 2 always ready

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                         input logic [1:0] s, input logic [31:0] d);
      logic [31:0] m;
      case (s)
         2'b00:   m = 32'h0000_00FF << (8 * a[1:0]);
         2'b01:   m = 32'h0000_FFFF << (16 * a[1]);
         default: m = 32'hFFFF_FFFF;
      endcase
      return (old & ~m) | (d & m);
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
   endfunction

   function automatic logic [31:0] cache_word(input logic [31:0] a);
      return cache_mem.exists(a >> 2) ? cache_mem[a >> 2] : 32'h0;
   endfunction

   always @(posedge clk) cyc++;

   // Cache responder: handshake inputs change mid-cycle, well clear of both edges.
   always @(posedge clk) begin
      #2;
      dbusy    = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
      dready_n = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 1) == 0);
   end

   // Monitor: pops expected stores/loads as the DUT presents them.
   always @(negedge clk) begin
      if (rst_n) begin
         check("occupancy_bound", 64'(occupancy > 3'(DEPTH)), 64'd0);
         if (dreq && !dwrite) begin
            check("load_before_drain", 64'(occupancy), 64'd0);
            rdata = cache_word(daddr);
         end else begin
            rdata = $urandom;
         end
         if (dreq && dwrite && !dbusy) begin
            if (exp_st.size() == 0) begin
               check("unexpected_drain", 64'(daddr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               st_t e;
               e = exp_st.pop_front();
               check("drain_addr", 64'(daddr), 64'(e.addr));
               check("drain_size", 64'(dsize), 64'(e.size));
               check("drain_data", 64'(ddata), 64'(e.data));
            end
            cache_mem[daddr >> 2] = merge(cache_word(daddr), daddr, dsize, ddata);
            last_drain_cyc = cyc;
            drain_cnt++;
         end
         if (load_valid) begin
            if (exp_ld.size() == 0) begin
               check("unexpected_load", 64'(load_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("load_data", 64'(load_data), 64'(exp_ld.pop_front()));
            end
            last_lv_cyc = cyc;
         end
      end
   end

   task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_size  = s;
      req_wdata = d;
      if (w) begin
         exp_st.push_back('{addr: a, size: s, data: d});
         ref_mem[a >> 2] = merge(ref_word(a), a, s, d);
      end else begin
         exp_ld.push_back(ref_word(a));
      end
   endtask

   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (stall && n < 300) begin
         n++;
         @(negedge clk);
      end
      check("accept_timeout", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      @(negedge clk);
      while (occupancy != 0 && n < 300) begin
         n++;
         @(negedge clk);
      end
      check("drain_timeout", 64'(occupancy), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_op(input logic [31:0] base, input bit allow_load);
      logic [1:0]  s;
      logic [31:0] a;
      logic        w;
      s = 2'($urandom_range(0, 2));
      a = base + 32'(4 * $urandom_range(0, 7));
      if (s == 2'b00) a = a + 32'($urandom_range(0, 3));
      if (s == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
      w = !allow_load || ($urandom_range(0, 9) < 6);
      issue(w, a, s, $urandom);
      wait_accept();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int d0;
      req_valid = 0; req_write = 0; req_addr = 0; req_size = 0; req_wdata = 0;
      dbusy = 0; dready_n = 1; rdata = 0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_stall", 64'(stall), 0);
      check("rst_dreq", 64'(dreq), 0);
      check("rst_dwrite", 64'(dwrite), 0);
      check("rst_load_valid", 64'(load_valid), 0);
      check("rst_occupancy", 64'(occupancy), 0);
      check("rst_daddr", 64'(daddr), 0);
      check("rst_dsize", 64'(dsize), 0);
      check("rst_ddata", 64'(ddata), 0);
      check("rst_load_data", 64'(load_data), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Burst into a busy cache: fifth store stalls until drain frees a slot.
      busy_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 32'h100 + 32'(4 * i), 2'b10, $urandom);
         wait_accept();
      end
      d0 = drain_cnt;
      issue(1'b1, 32'h110, 2'b10, $urandom);
      @(negedge clk);
      check("t2_stall_full", 64'(stall), 1);
      check("t2_occupancy_full", 64'(occupancy), 4);
      busy_mode = 2;
      wait_accept();
      wait_drain();
      check("t2_drain_count", 64'(drain_cnt - d0), 5);

      // Load after store without forwarding: write reaches the cache first.
      ready_mode = 2;
      issue(1'b1, 32'h200, 2'b10, 32'hDEAD_BEEF);
      wait_accept();
      issue(1'b0, 32'h200, 2'b10, $urandom);
      wait_accept();
      check("t3_load_data", 64'(load_data), 64'hDEAD_BEEF);
`ifndef STB_FWD_EN
      check("t3_latency", 64'(last_lv_cyc - last_drain_cyc), 3);
`endif

`ifdef STB_FWD_EN
      busy_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      issue(1'b1, 32'h40, 2'b10, 32'h11);
      wait_accept();
      issue(1'b1, 32'h40, 2'b10, 32'h22);
      wait_accept();
      issue(1'b0, 32'h40, 2'b10, $urandom);
      @(negedge clk);
      check("t4_no_dreq", 64'(dreq), 0);
      check("t4_stall", 64'(stall), 1);
      @(negedge clk);
      check("t4_valid", 64'(load_valid), 1);
      check("t4_data", 64'(load_data), 64'h22);
      @(posedge clk);
      #1 req_valid = 1'b0;
      busy_mode = 2;
      wait_drain();
`endif

      // Partial overlap: byte store blocks the word load until the buffer is empty.
      busy_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      issue(1'b1, 32'h41, 2'b00, 32'h0000_AB00);
      wait_accept();
      issue(1'b0, 32'h40, 2'b10, $urandom);
      repeat (4) @(negedge clk);
      check("t5_hold_stall", 64'(stall), 1);
      check("t5_hold_valid", 64'(load_valid), 0);
      check("t5_occupancy", 64'(occupancy), 1);
      busy_mode = 2;
      wait_accept();

      // Reset while a cache read is outstanding.
      ready_mode = 1;
      issue(1'b0, 32'h200, 2'b10, $urandom);
      begin
         int n = 0;
         @(negedge clk);
         while (!(dreq && !dwrite) && n < 50) begin
            n++;
            @(negedge clk);
         end
         check("t1_load_issued", 64'(dreq && !dwrite), 1);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t1_dreq", 64'(dreq), 0);
      check("t1_stall", 64'(stall), 0);
      check("t1_occupancy", 64'(occupancy), 0);
      check("t1_load_valid", 64'(load_valid), 0);
      req_valid = 1'b0;
      exp_ld.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Pointer wrap with random cache backpressure, then a random mix.
      busy_mode  = 0;
      ready_mode = 0;
      for (int i = 0; i < 3 * DEPTH; i++) rand_op(32'h300, 1'b0);
      for (int i = 0; i < 150; i++) rand_op(32'h300, 1'b1);
      busy_mode = 2;
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      check("left_stores", 64'(exp_st.size()), 0);
      check("left_loads", 64'(exp_ld.size()), 0);
      foreach (ref_mem[k]) check("final_mem", 64'(cache_word(k << 2)), 64'(ref_mem[k]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
